// File: rtl/resv_station_pkg.sv
// rtl/resv_station_pkg.sv - shared widths and entry record for the age-ordered reservation station
package resv_station;
  localparam int PHYS_REGS  = 64;
  localparam int FUNC_UNITS = 4;
  localparam int BR_W       = 4;
  localparam int PAYLOAD_W  = 64;
  localparam int PREG_W     = $clog2(PHYS_REGS);
  localparam int FU_W       = $clog2(FUNC_UNITS);
  localparam int BR_IDX_W   = $clog2(BR_W);

  typedef struct packed {
    logic [PREG_W-1:0]    ps1;
    logic [PREG_W-1:0]    ps2;
    logic [PREG_W-1:0]    pd;
    logic [FU_W-1:0]      fu;
    logic                 imm_opt;
    logic                 ps1_rdy;
    logic                 ps2_rdy;
    logic [BR_W-1:0]      br_mask;
    logic [PAYLOAD_W-1:0] payload;
    logic                 valid;
  } resv_age_entry_t;

  // preg 0 is hardwired ready and never tracked in the busy table
  function automatic logic preg_is_zero(input logic [PREG_W-1:0] p);
    return p == '0;
  endfunction
endpackage

// File: rtl/age_select.sv
// rtl/age_select.sv - picks the oldest requester using an age matrix
module age_select #(
  parameter int N = 16
) (
  input  logic [N-1:0][N-1:0] age,
  input  logic [N-1:0]        req,
  output logic [N-1:0]        grant,
  output logic                any
);
  logic [N-1:0] blocked;

  // age[j][i] set means entry j is older than entry i
  always_comb begin
    blocked = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (req[j] && age[j][i]) blocked[i] = 1'b1;
      end
    end
    grant = req & ~blocked;
  end

  assign any = |req;
endmodule

// File: rtl/resv_age_queue.sv
// rtl/resv_age_queue.sv - multi-dispatch reservation station with oldest-ready select per unit
module resv_age_queue
  import resv_station::*;
#(
  parameter  int ENTRIES = 16,
  parameter  int DISP_W  = 2,
  parameter  int CDB_W   = 4,
  localparam int SLOT_W  = $clog2(ENTRIES),
  localparam int CNT_W   = $clog2(ENTRIES) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DISP_W-1:0]                    disp_valid,
  input  logic [DISP_W-1:0][PREG_W-1:0]        disp_ps1,
  input  logic [DISP_W-1:0][PREG_W-1:0]        disp_ps2,
  input  logic [DISP_W-1:0][PREG_W-1:0]        disp_pd,
  input  logic [DISP_W-1:0][FU_W-1:0]          disp_fu,
  input  logic [DISP_W-1:0]                    disp_imm_opt,
  input  logic [DISP_W-1:0][BR_W-1:0]          disp_br_mask,
  input  logic [DISP_W-1:0][PAYLOAD_W-1:0]     disp_payload,
  output logic [CNT_W-1:0]                     free_cnt,
  input  logic [CDB_W-1:0]                     cdb_valid,
  input  logic [CDB_W-1:0][PREG_W-1:0]         cdb_pd,
  input  logic                                 br_valid,
  input  logic                                 br_mispred,
  input  logic [BR_IDX_W-1:0]                  br_idx,
  output logic [FUNC_UNITS-1:0]                iss_valid,
  input  logic [FUNC_UNITS-1:0]                iss_ready,
  output logic [FUNC_UNITS-1:0][PREG_W-1:0]    iss_ps1,
  output logic [FUNC_UNITS-1:0][PREG_W-1:0]    iss_ps2,
  output logic [FUNC_UNITS-1:0][PREG_W-1:0]    iss_pd,
  output logic [FUNC_UNITS-1:0][BR_W-1:0]      iss_br_mask,
  output logic [FUNC_UNITS-1:0][PAYLOAD_W-1:0] iss_payload
);
  resv_age_entry_t                   ent   [ENTRIES];
  resv_age_entry_t                   ent_n [ENTRIES];
  logic [ENTRIES-1:0][ENTRIES-1:0]   age, age_n;
  logic [PHYS_REGS-1:0]              busy, busy_n;
  logic [ENTRIES-1:0]                valid_vec, valid_n_vec;
  logic [FUNC_UNITS-1:0][ENTRIES-1:0] req, grant;
  logic [DISP_W-1:0][SLOT_W-1:0]     lane_slot;
  logic [DISP_W-1:0]                 lane_has_slot, lane_go;
  logic                              mispred, resolved;

  assign mispred  = br_valid & br_mispred;
  assign resolved = br_valid & ~br_mispred;

  function automatic logic cdb_hit(input logic [PREG_W-1:0] p,
                                   input logic [CDB_W-1:0] v,
                                   input logic [CDB_W-1:0][PREG_W-1:0] pds);
    logic h;
    h = 1'b0;
    for (int c = 0; c < CDB_W; c++) begin
      if (v[c] && pds[c] == p) h = 1'b1;
    end
    return h;
  endfunction

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_vec[i]   = ent[i].valid;
      valid_n_vec[i] = ent_n[i].valid;
    end
  end

  // Lane k takes the k-th lowest free slot; slots freed this cycle are not yet visible
  always_comb begin
    int nfree;
    nfree         = 0;
    lane_slot     = '0;
    lane_has_slot = '0;
    for (int s = 0; s < ENTRIES; s++) begin
      if (!ent[s].valid) begin
        for (int k = 0; k < DISP_W; k++) begin
          if (nfree == k) begin
            lane_slot[k]     = SLOT_W'(s);
            lane_has_slot[k] = 1'b1;
          end
        end
        nfree++;
      end
    end
    for (int k = 0; k < DISP_W; k++) begin
      lane_go[k] = disp_valid[k] & lane_has_slot[k] & ~(mispred & disp_br_mask[k][br_idx]);
    end
  end

  always_comb begin
    for (int f = 0; f < FUNC_UNITS; f++) begin
      for (int i = 0; i < ENTRIES; i++) begin
        req[f][i] = ent[i].valid && (ent[i].fu == FU_W'(f)) && ent[i].ps1_rdy &&
                    (ent[i].ps2_rdy || ent[i].imm_opt);
      end
    end
  end

  for (genvar f = 0; f < FUNC_UNITS; f++) begin : g_fu
    age_select #(.N(ENTRIES)) u_sel (
      .age   (age),
      .req   (req[f]),
      .grant (grant[f]),
      .any   (iss_valid[f])
    );
  end

  always_comb begin
    iss_ps1     = '0;
    iss_ps2     = '0;
    iss_pd      = '0;
    iss_br_mask = '0;
    iss_payload = '0;
    for (int f = 0; f < FUNC_UNITS; f++) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (grant[f][i]) begin
          iss_ps1[f]     = ent[i].ps1;
          iss_ps2[f]     = ent[i].ps2;
          iss_pd[f]      = ent[i].pd;
          iss_br_mask[f] = ent[i].br_mask;
          iss_payload[f] = ent[i].payload;
        end
      end
    end
  end

  always_comb begin
    resv_age_entry_t    e;
    logic [ENTRIES-1:0] older;
    logic               issued;
    e      = '0;
    older  = '0;
    issued = 1'b0;
    ent_n  = ent;
    age_n  = age;
    busy_n = busy;

    for (int i = 0; i < ENTRIES; i++) begin
      issued = 1'b0;
      for (int f = 0; f < FUNC_UNITS; f++) issued = issued | (grant[f][i] & iss_ready[f]);
      if (issued || (mispred && ent[i].br_mask[br_idx])) ent_n[i].valid = 1'b0;
      if (resolved) ent_n[i].br_mask[br_idx] = 1'b0;
      if (cdb_hit(ent[i].ps1, cdb_valid, cdb_pd)) ent_n[i].ps1_rdy = 1'b1;
      if (cdb_hit(ent[i].ps2, cdb_valid, cdb_pd)) ent_n[i].ps2_rdy = 1'b1;
    end

    for (int k = 0; k < DISP_W; k++) begin
      if (lane_go[k]) begin
        e.ps1     = disp_ps1[k];
        e.ps2     = disp_ps2[k];
        e.pd      = disp_pd[k];
        e.fu      = disp_fu[k];
        e.imm_opt = disp_imm_opt[k];
        e.payload = disp_payload[k];
        e.valid   = 1'b1;
        e.br_mask = disp_br_mask[k];
        if (resolved) e.br_mask[br_idx] = 1'b0;
        e.ps1_rdy = preg_is_zero(disp_ps1[k]) || !busy[disp_ps1[k]] ||
                    cdb_hit(disp_ps1[k], cdb_valid, cdb_pd);
        e.ps2_rdy = preg_is_zero(disp_ps2[k]) || !busy[disp_ps2[k]] ||
                    cdb_hit(disp_ps2[k], cdb_valid, cdb_pd);
        // A producer in an earlier lane overrides any same-cycle CDB hit (that CDB is older)
        for (int j = 0; j < k; j++) begin
          if (disp_valid[j] && !preg_is_zero(disp_pd[j])) begin
            if (disp_pd[j] == disp_ps1[k]) e.ps1_rdy = 1'b0;
            if (disp_pd[j] == disp_ps2[k]) e.ps2_rdy = 1'b0;
          end
        end
        ent_n[lane_slot[k]] = e;
        age_n[lane_slot[k]] = '0;
      end
    end

    for (int k = 0; k < DISP_W; k++) begin
      if (lane_go[k]) begin
        older = valid_vec;
        for (int j = 0; j < k; j++) begin
          if (lane_go[j]) older[lane_slot[j]] = 1'b1;
        end
        for (int r = 0; r < ENTRIES; r++) age_n[r][lane_slot[k]] = older[r];
      end
    end

    // Set wins over a same-cycle clear: the CDB belongs to an older producer
    for (int p = 0; p < PHYS_REGS; p++) begin
      if (cdb_hit(PREG_W'(p), cdb_valid, cdb_pd)) busy_n[p] = 1'b0;
    end
    for (int k = 0; k < DISP_W; k++) begin
      if (disp_valid[k] && !preg_is_zero(disp_pd[k])) busy_n[disp_pd[k]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
      age      <= '0;
      busy     <= '0;
      free_cnt <= CNT_W'(ENTRIES);
    end else begin
      for (int i = 0; i < ENTRIES; i++) ent[i] <= ent_n[i];
      age      <= age_n;
      busy     <= busy_n;
      free_cnt <= CNT_W'(ENTRIES - $countones(valid_n_vec));
    end
  end

  a_disp_overflow: assert property (@(posedge clk) disable iff (rst)
    CNT_W'($countones(disp_valid)) <= free_cnt);
endmodule

// File: tb/tb_resv_age_queue.sv
// tb/tb_resv_age_queue.sv - self-checking bench for resv_age_queue
module tb_resv_age_queue;
  import resv_station::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [1:0]              disp_valid;
  logic [1:0][5:0]         disp_ps1, disp_ps2, disp_pd;
  logic [1:0][1:0]         disp_fu;
  logic [1:0]              disp_imm_opt;
  logic [1:0][3:0]         disp_br_mask;
  logic [1:0][63:0]        disp_payload;
  logic [4:0]              free_cnt;
  logic [3:0]              cdb_valid;
  logic [3:0][5:0]         cdb_pd;
  logic                    br_valid, br_mispred;
  logic [1:0]              br_idx;
  logic [3:0]              iss_valid, iss_ready;
  logic [3:0][5:0]         iss_ps1, iss_ps2, iss_pd;
  logic [3:0][3:0]         iss_br_mask;
  logic [3:0][63:0]        iss_payload;

  always #5 clk = ~clk;

  resv_age_queue #(.ENTRIES(16), .DISP_W(2), .CDB_W(4)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ps1(disp_ps1), .disp_ps2(disp_ps2), .disp_pd(disp_pd),
    .disp_fu(disp_fu), .disp_imm_opt(disp_imm_opt), .disp_br_mask(disp_br_mask),
    .disp_payload(disp_payload), .free_cnt(free_cnt),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
    .br_valid(br_valid), .br_mispred(br_mispred), .br_idx(br_idx),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_ps1(iss_ps1), .iss_ps2(iss_ps2), .iss_pd(iss_pd),
    .iss_br_mask(iss_br_mask), .iss_payload(iss_payload)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    disp_valid = '0; disp_ps1 = '0; disp_ps2 = '0; disp_pd = '0; disp_fu = '0;
    disp_imm_opt = '0; disp_br_mask = '0; disp_payload = '0;
    cdb_valid = '0; cdb_pd = '0;
    br_valid = 1'b0; br_mispred = 1'b0; br_idx = '0;
    iss_ready = '1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input logic [5:0] ps1, input logic [5:0] pd,
                          input logic [1:0] fu, input logic [3:0] mask, input logic [63:0] pl);
    disp_valid[k] = 1'b1; disp_ps1[k] = ps1; disp_ps2[k] = 6'd0; disp_pd[k] = pd;
    disp_fu[k] = fu; disp_imm_opt[k] = 1'b0; disp_br_mask[k] = mask; disp_payload[k] = pl;
  endtask

  // Reference model: entries kept oldest-first in a queue, busy table as a bit vector
  typedef struct {
    logic [5:0]  ps1, ps2, pd;
    logic [1:0]  fu;
    logic        imm, r1, r2;
    logic [3:0]  mask;
    logic [63:0] pl;
  } m_ent_t;
  m_ent_t      mq[$];
  logic [63:0] mbusy;

  function automatic int m_pick(input int f);
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].fu == 2'(f) && mq[i].r1 && (mq[i].r2 || mq[i].imm)) return i;
    return -1;
  endfunction

  function automatic bit cdb_has(input logic [5:0] p);
    for (int c = 0; c < 4; c++) if (cdb_valid[c] && cdb_pd[c] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_src_ready(input int k, input logic [5:0] ps);
    if (ps == 6'd0) return 1'b1;
    for (int j = 0; j < k; j++) if (disp_valid[j] && disp_pd[j] == ps) return 1'b0;
    return !mbusy[ps] || cdb_has(ps);
  endfunction

  task automatic m_step();
    m_ent_t nq[$];
    m_ent_t e;
    int     p[4];
    bit     gone;
    bit     mis, cor;
    mis = br_valid && br_mispred;
    cor = br_valid && !br_mispred;
    for (int f = 0; f < 4; f++) p[f] = m_pick(f);
    for (int i = 0; i < mq.size(); i++) begin
      e = mq[i];
      gone = 1'b0;
      for (int f = 0; f < 4; f++) if (p[f] == i && iss_ready[f]) gone = 1'b1;
      if (mis && e.mask[br_idx]) gone = 1'b1;
      if (!gone) begin
        if (cor) e.mask[br_idx] = 1'b0;
        if (cdb_has(e.ps1)) e.r1 = 1'b1;
        if (cdb_has(e.ps2)) e.r2 = 1'b1;
        nq.push_back(e);
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (disp_valid[k] && !(mis && disp_br_mask[k][br_idx])) begin
        e.ps1 = disp_ps1[k]; e.ps2 = disp_ps2[k]; e.pd = disp_pd[k]; e.fu = disp_fu[k];
        e.imm = disp_imm_opt[k]; e.pl = disp_payload[k]; e.mask = disp_br_mask[k];
        if (cor) e.mask[br_idx] = 1'b0;
        e.r1 = m_src_ready(k, disp_ps1[k]);
        e.r2 = m_src_ready(k, disp_ps2[k]);
        nq.push_back(e);
      end
    end
    for (int q = 0; q < 64; q++) if (cdb_has(6'(q))) mbusy[q] = 1'b0;
    for (int k = 0; k < 2; k++) if (disp_valid[k] && disp_pd[k] != 6'd0) mbusy[disp_pd[k]] = 1'b1;
    mq = nq;
  endtask

  typedef struct {
    logic        dv;
    logic [5:0]  ps1, pd;
    logic [1:0]  fu;
    logic [63:0] pl;
    logic        cdb_v;
    logic [5:0]  cdb_p;
    logic [3:0]  rdy;
    logic [3:0]  exp_valid;
    logic [1:0]  exp_fu;
    logic [63:0] exp_pl;
    logic [4:0]  exp_free;
  } vec_t;
  vec_t vt [11];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tag;
    tag = 0;
    // Wakeup ordering (rows 0-4) and backpressure hold (rows 5-10)
    vt[0]  = '{1'b1, 6'd0, 6'd5,  2'd2, 64'h10, 1'b0, 6'd0, 4'hf, 4'b0100, 2'd2, 64'h10, 5'd15};
    vt[1]  = '{1'b1, 6'd5, 6'd6,  2'd0, 64'hA,  1'b0, 6'd0, 4'hf, 4'b0000, 2'd0, 64'h0,  5'd15};
    vt[2]  = '{1'b1, 6'd0, 6'd7,  2'd0, 64'hB,  1'b0, 6'd0, 4'hf, 4'b0001, 2'd0, 64'hB,  5'd14};
    vt[3]  = '{1'b0, 6'd0, 6'd0,  2'd0, 64'h0,  1'b1, 6'd5, 4'hf, 4'b0001, 2'd0, 64'hA,  5'd15};
    vt[4]  = '{1'b0, 6'd0, 6'd0,  2'd0, 64'h0,  1'b0, 6'd0, 4'hf, 4'b0000, 2'd0, 64'h0,  5'd16};
    vt[5]  = '{1'b1, 6'd0, 6'd8,  2'd1, 64'hC,  1'b0, 6'd0, 4'hd, 4'b0010, 2'd1, 64'hC,  5'd15};
    vt[6]  = '{1'b1, 6'd0, 6'd10, 2'd1, 64'hD,  1'b0, 6'd0, 4'hd, 4'b0010, 2'd1, 64'hC,  5'd14};
    vt[7]  = '{1'b0, 6'd0, 6'd0,  2'd0, 64'h0,  1'b0, 6'd0, 4'hd, 4'b0010, 2'd1, 64'hC,  5'd14};
    vt[8]  = '{1'b0, 6'd0, 6'd0,  2'd0, 64'h0,  1'b0, 6'd0, 4'hd, 4'b0010, 2'd1, 64'hC,  5'd14};
    vt[9]  = '{1'b0, 6'd0, 6'd0,  2'd0, 64'h0,  1'b0, 6'd0, 4'hf, 4'b0010, 2'd1, 64'hD,  5'd15};
    vt[10] = '{1'b0, 6'd0, 6'd0,  2'd0, 64'h0,  1'b0, 6'd0, 4'hf, 4'b0000, 2'd0, 64'h0,  5'd16};

    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("reset_free_cnt", 64'(free_cnt), 64'd16);
      check("reset_iss_valid", 64'(iss_valid), 64'd0);
      tick();
    end

    for (int i = 0; i < 11; i++) begin
      clear_inputs();
      if (vt[i].dv) set_lane(0, vt[i].ps1, vt[i].pd, vt[i].fu, 4'd0, vt[i].pl);
      cdb_valid[0] = vt[i].cdb_v;
      cdb_pd[0]    = vt[i].cdb_p;
      iss_ready    = vt[i].rdy;
      tick();
      check($sformatf("vec%0d_iss_valid", i), 64'(iss_valid), 64'(vt[i].exp_valid));
      if (vt[i].exp_valid[vt[i].exp_fu])
        check($sformatf("vec%0d_payload", i), iss_payload[vt[i].exp_fu], vt[i].exp_pl);
      check($sformatf("vec%0d_free_cnt", i), 64'(free_cnt), 64'(vt[i].exp_free));
    end

    // Intra-bundle dependence beats a same-cycle CDB hit on the same preg
    clear_inputs();
    set_lane(0, 6'd0, 6'd9,  2'd3, 4'd0, 64'h40);
    set_lane(1, 6'd9, 6'd11, 2'd3, 4'd0, 64'h41);
    cdb_valid[0] = 1'b1; cdb_pd[0] = 6'd9;
    tick();
    check("bundle_first_valid", 64'(iss_valid), 64'b1000);
    check("bundle_first_payload", iss_payload[3], 64'h40);
    check("bundle_free", 64'(free_cnt), 64'd14);
    clear_inputs();
    tick();
    check("bundle_dep_waits", 64'(iss_valid[3]), 64'd0);
    tick();
    check("bundle_dep_still_waits", 64'(iss_valid[3]), 64'd0);
    cdb_valid[0] = 1'b1; cdb_pd[0] = 6'd9;
    tick();
    clear_inputs();
    check("bundle_dep_woken", 64'(iss_valid[3]), 64'd1);
    check("bundle_dep_payload", iss_payload[3], 64'h41);
    tick();
    check("bundle_drained", 64'(free_cnt), 64'd16);

    // Fill all slots, then mispredict kills the 10 entries tagged with bit 2
    for (int c = 0; c < 8; c++) begin
      clear_inputs();
      iss_ready = '0;
      for (int k = 0; k < 2; k++) begin
        int n;
        n = 2 * c + k;
        set_lane(k, 6'd0, 6'd0, 2'd0, (n % 3 != 0) ? 4'b0100 : 4'b0000, 64'h500 + 64'(n));
      end
      tick();
    end
    check("fill_free_zero", 64'(free_cnt), 64'd0);
    clear_inputs();
    iss_ready = '0;
    br_valid = 1'b1; br_mispred = 1'b1; br_idx = 2'd2;
    tick();
    check("kill_free_cnt", 64'(free_cnt), 64'd10);
    clear_inputs();
    for (int n = 0; n < 16; n += 3) begin
      check($sformatf("survivor%0d_valid", n), 64'(iss_valid[0]), 64'd1);
      check($sformatf("survivor%0d_payload", n), iss_payload[0], 64'h500 + 64'(n));
      tick();
    end
    check("survivors_drained", 64'(free_cnt), 64'd16);

    // Correct resolve clears the bit on stored and incoming masks
    clear_inputs();
    iss_ready = 4'b1101;
    set_lane(0, 6'd0, 6'd0, 2'd1, 4'b0010, 64'h60);
    tick();
    check("resolve_old_mask_before", 64'(iss_br_mask[1]), 64'b0010);
    clear_inputs();
    iss_ready = 4'b1101;
    br_valid = 1'b1; br_idx = 2'd1;
    set_lane(0, 6'd0, 6'd0, 2'd1, 4'b0010, 64'h61);
    tick();
    check("resolve_old_mask_after", 64'(iss_br_mask[1]), 64'd0);
    check("resolve_free", 64'(free_cnt), 64'd14);
    clear_inputs();
    iss_ready = 4'b1101;
    br_valid = 1'b1; br_mispred = 1'b1; br_idx = 2'd1;
    tick();
    check("late_mispredict_no_kill", 64'(free_cnt), 64'd14);
    clear_inputs();
    tick();
    check("resolve_new_payload", iss_payload[1], 64'h61);
    check("resolve_new_mask", 64'(iss_br_mask[1]), 64'd0);
    tick();
    check("resolve_drained", 64'(free_cnt), 64'd16);

    // Randomised traffic against the queue model
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq.delete();
    mbusy = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int pk, nl, lim;
      for (int f = 0; f < 4; f++) begin
        pk = m_pick(f);
        check("rand_iss_valid", 64'(iss_valid[f]), 64'(pk >= 0));
        if (pk >= 0) begin
          check("rand_payload", iss_payload[f], mq[pk].pl);
          check("rand_pd", 64'(iss_pd[f]), 64'(mq[pk].pd));
          check("rand_ps1", 64'(iss_ps1[f]), 64'(mq[pk].ps1));
          check("rand_ps2", 64'(iss_ps2[f]), 64'(mq[pk].ps2));
          check("rand_br_mask", 64'(iss_br_mask[f]), 64'(mq[pk].mask));
        end
      end
      check("rand_free_cnt", 64'(free_cnt), 64'(16 - mq.size()));

      clear_inputs();
      lim = (16 - mq.size() < 2) ? 16 - mq.size() : 2;
      nl  = int'($urandom_range(0, lim));
      for (int k = 0; k < nl; k++) begin
        disp_valid[k]   = 1'b1;
        disp_ps1[k]     = 6'($urandom_range(0, 15));
        disp_ps2[k]     = 6'($urandom_range(0, 15));
        disp_pd[k]      = 6'($urandom_range(0, 15));
        disp_fu[k]      = 2'($urandom_range(0, 3));
        disp_imm_opt[k] = ($urandom_range(0, 3) == 0);
        disp_br_mask[k] = 4'($urandom_range(0, 15));
        disp_payload[k] = {32'(cyc), 32'(tag)};
        tag++;
      end
      for (int c = 0; c < 4; c++) begin
        cdb_valid[c] = ($urandom_range(0, 3) == 0);
        cdb_pd[c]    = 6'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 9) == 0) begin
        br_valid   = 1'b1;
        br_mispred = 1'($urandom_range(0, 1));
        br_idx     = 2'($urandom_range(0, 3));
      end
      iss_ready = 4'($urandom_range(0, 15));
      m_step();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
